// File: rtl/mad_search_ctrl.sv
// mad_search_ctrl: full-search sequencer for the MAD3 SAD pipeline, tracking minimum SAD and its address.
// Define MAD_EARLY_EXIT_EN to stop issuing once a zero SAD is accepted.
module mad_search_ctrl #(
    parameter int NUM_POS = 49,
    parameter int MAD_LAT = 6,
    parameter int SAD_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SAD_W+8:0] mad_res,
    output logic [5:0]       sr_addressRead,
    output logic             sr_rd_en,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [7:0]       best_addr
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t             state_q, state_d;
    logic [5:0]         addr_q, addr_d;
    logic [MAD_LAT-1:0] pipe_q, pipe_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [7:0]         best_addr_q, best_addr_d;
    logic [SAD_W-1:0]   sad;
    logic               vld_o, take, last, early, launch, unused_msb;
    assign sad        = mad_res[SAD_W+7:8];
    assign unused_msb = mad_res[SAD_W+8];
    assign vld_o      = pipe_q[MAD_LAT-1];
    assign take       = vld_o && (sad < best_sad_q);
    assign last       = addr_q == 6'(NUM_POS - 1);
    assign launch     = (state_q == IDLE) && start;
`ifdef MAD_EARLY_EXIT_EN
    assign early = take && (sad == '0);
`else
    assign early = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pipe_q      <= '0;
            best_sad_q  <= '1;
            best_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pipe_q      <= pipe_d;
            best_sad_q  <= best_sad_d;
            best_addr_q <= best_addr_d;
        end
    end
    // DRAIN leaves one cycle early so the final compare lands together with done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? ISSUE : IDLE;
            ISSUE:   state_d = (last || early) ? DRAIN : ISSUE;
            DRAIN:   state_d = (pipe_d == '0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        sr_rd_en = state_q == ISSUE;
        busy     = (state_q == ISSUE) || (state_q == DRAIN);
        done     = state_q == DONE;
    end
    always_comb begin
        pipe_d      = MAD_LAT'({pipe_q, sr_rd_en});
        addr_d      = launch ? '0 : (sr_rd_en && !last && !early) ? addr_q + 6'd1 : addr_q;
        best_sad_d  = launch ? '1 : take ? sad : best_sad_q;
        best_addr_d = launch ? '0 : take ? mad_res[7:0] : best_addr_q;
    end
    assign sr_addressRead = addr_q;
    assign best_sad       = best_sad_q;
    assign best_addr      = best_addr_q;
endmodule

// File: tb/tb_mad_search_ctrl.sv
// tb_mad_search_ctrl: directed bench for mad_search_ctrl with a MAD3 latency model in front of mad_res.
module tb_mad_search_ctrl;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [20:0] mad_res;
    logic [5:0]  sr_addressRead;
    logic        sr_rd_en, busy, done;
    logic [11:0] best_sad;
    logic [7:0]  best_addr;
    int          n_chk = 0, n_fail = 0, mode = 0;
    int          rd_total = 0, done_total = 0, rd_base, dn_base, n;
    int          seen_total[64], seen_base[64];
    logic [5:0][5:0] hist = '0;
    logic [5:0]  vh = '0;
`ifdef MAD_EARLY_EXIT_EN
    localparam int EX_LAST = 11, EX_DONE = 19;
`else
    localparam int EX_LAST = 48, EX_DONE = 56;
`endif

    mad_search_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mad_res(mad_res),
        .sr_addressRead(sr_addressRead), .sr_rd_en(sr_rd_en), .busy(busy),
        .done(done), .best_sad(best_sad), .best_addr(best_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] resp(input int m, input logic [5:0] k);
        int s;
        s = (m == 0) ? 100 - int'(k) : (m == 1) ? ((k == 10 || k == 20) ? 7 : 300) : (k == 5 ? 0 : 50);
        return {1'b1, 12'(s), 2'b00, k};
    endfunction

    // Result for the position issued MAD_LAT cycles ago; a bait SAD of 1 when nothing is in flight
    always_comb mad_res = vh[5] ? resp(mode, hist[5]) : {1'b0, 12'd1, 8'hEE};

    initial foreach (seen_total[i]) seen_total[i] = 0;

    always @(posedge clk) begin
        hist <= {hist[4:0], sr_addressRead};
        vh   <= {vh[4:0], sr_rd_en};
        if (sr_rd_en) begin
            rd_total = rd_total + 1;
            seen_total[sr_addressRead] = seen_total[sr_addressRead] + 1;
        end
        if (done) done_total = done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark();
        rd_base   = rd_total;
        dn_base   = done_total;
        seen_base = seen_total;
    endtask

    task automatic run_pass(input int re1, input int re2, output int cyc);
        mark();
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == re1) || (cyc == re2);
        end while (!done && cyc < 200);
        start = 1'b0;
    endtask

    task automatic check_seen(input string tag, input int last_pos);
        logic ok = 1'b1;
        for (int i = 0; i < 64; i++)
            if (seen_total[i] - seen_base[i] != ((i <= last_pos) ? 1 : 0)) ok = 1'b0;
        check(tag, ok, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_sad", best_sad, 12'hFFF);
        check("rst_best_addr", best_addr, 0);
        check("rst_rd_en", sr_rd_en, 0);
        check("rst_addr", sr_addressRead, 0);

        mode = 0;
        run_pass(0, 0, n);
        check("p0_done_cycle", n, 56);
        check("p0_best_sad", best_sad, 52);
        check("p0_best_addr", best_addr, 48);
        check("p0_addr_hold", sr_addressRead, 48);
        check("p0_rd_cnt", rd_total - rd_base, 49);
        check_seen("p0_seen", 48);
        @(negedge clk);
        check("p0_done_pulse", done, 0);
        check("p0_idle_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("p0_best_hold", best_sad, 52);

        mode = 1;
        run_pass(0, 0, n);
        check("p1_done_cycle", n, 56);
        check("p1_best_sad", best_sad, 7);
        check("p1_best_addr", best_addr, 10);
        @(negedge clk);

        mode = 0;
        run_pass(5, 30, n);
        check("p2_done_cycle", n, 56);
        repeat (4) @(negedge clk);
        check("p2_done_cnt", done_total - dn_base, 1);
        check("p2_rd_cnt", rd_total - rd_base, 49);
        check("p2_best_sad", best_sad, 52);

        mark();
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (c == 20);
        end
        check("p3_mid_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        check("p3_rst_busy", busy, 0);
        check("p3_rst_rd_en", sr_rd_en, 0);
        check("p3_rst_best_sad", best_sad, 12'hFFF);
        check("p3_rst_best_addr", best_addr, 0);
        repeat (60) @(negedge clk);
        check("p3_no_done", done_total - dn_base, 0);
        run_pass(0, 0, n);
        check("p3_re_done_cycle", n, 56);
        check("p3_re_best_sad", best_sad, 52);
        check("p3_re_best_addr", best_addr, 48);
        check("p3_re_rd_cnt", rd_total - rd_base, 49);
        @(negedge clk);

        mode = 2;
        run_pass(0, 0, n);
        check("p4_done_cycle", n, EX_DONE);
        check("p4_best_sad", best_sad, 0);
        check("p4_best_addr", best_addr, 5);
        check("p4_addr_hold", sr_addressRead, EX_LAST);
        check("p4_rd_cnt", rd_total - rd_base, EX_LAST + 1);
        check_seen("p4_seen", EX_LAST);
        @(negedge clk);
        check("p4_done_pulse", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
